tick_gen_multi: RTL and testbench
=================================

Name: tick_gen_multi

Overview:
- Parametrised multi-channel tick generator; next generation of the fixed per/rtc/baud clock dividers.
- Produces one-cycle enable pulses (ticks) on the cpu clock for the peripheral, RTC (CLINT mtime) and UART bit-rate domains.
- Adds runtime-programmable divisors, a fractional mode for exact baud rates, per-channel enable and phase restart.
- Sits beside the CLINT and UART; consumers sample `tick_o[ch]` as a clock enable.

Parameters:
- NCH, 3, number of channels.
- DIV_W, 16, integer divisor width.
- FRAC_W, 8, fractional divisor width (units of 1/2^FRAC_W cycle).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- en_i  in  NCH  per-channel enable.
- sync_i  in  NCH  per-channel phase restart pulse.
- cfg_wen  in  1  config write strobe.
- cfg_ch  in  $clog2(NCH)  target channel.
- cfg_div  in  DIV_W  integer divisor.
- cfg_frac  in  FRAC_W  fractional divisor.
- tick_o  out  NCH  one-cycle tick per channel.
- pend_o  out  NCH  shadow config waiting to be applied.

Behaviour:
- Reset (reset==0 at a clock edge):
  - tick_o=0, pend_o=0, all counters and accumulators 0.
  - Active and shadow config load the package defaults: ch0 div=5 frac=0; ch1 div=1000 frac=0; ch2 div=8680 frac=141.
  - Channels with no default entry (ch>=3): div=1 frac=0.
- Per channel, each clock with en_i=1:
  - If cnt == len-1: tick_o=1 (registered, asserted the following cycle) and cnt<=0. Otherwise cnt<=cnt+1.
  - len = max(div,1) + carry.
  - carry is the registered carry-out of `{1'b0,acc} + frac`, computed at the previous tick. acc<=acc+frac (mod 2^FRAC_W) at each tick.
  - Average period = div + frac/2^FRAC_W cycles.
  - frac=0 gives an exact integer period; div=0 or 1 with frac=0 ticks every cycle.
- First tick after reset or sync occurs `len` cycles after the release/sync edge; carry is 0 for the first period.
- en_i=0:
  - cnt, acc and carry held at 0; tick_o=0.
  - Shadow config is still applied immediately.
  - After en_i rises, the first tick comes after `len` cycles.
- cfg_wen:
  - Writes shadow[cfg_ch]={cfg_div,cfg_frac} and sets pend_o[cfg_ch].
  - Shadow is copied to active on the cycle the channel's tick is produced, or immediately if the channel is disabled or sync_i is set. pend_o then clears.
  - A second write before application overwrites the shadow; the last write wins.
  - Changing a divisor never produces a truncated or glitched period.
- sync_i[ch]=1: cnt, acc, carry <=0; pending shadow applied; no tick that cycle.
- Same-cycle cfg_wen and sync_i on one channel: the new config is applied immediately and used for the following period.
- Same-cycle cfg_wen and natural tick: the tick uses the old config; the new config is written to shadow and applied at the next tick (pend_o=1 meanwhile).
- Channels are fully independent; no cross-channel interaction.
- Reset mid-period aborts cleanly: no tick in the reset cycle.

Decomposition:
- Shared package: cpu_freq/per_freq/rtc_freq/baudrate constants; derived divisors; frac defaults (e.g. round(frac(cpu_freq/baudrate)*2^FRAC_W)=141); a packed `tick_cfg_t {div, frac}` struct; default-config array indexed by channel.
- One sub-module: tick_chan (single-channel counter, accumulator, shadow), generated NCH times. The top level handles the cfg_ch decode only.

Test Plan:
1. Reset release, en_i=3'b111, defaults -> ch0 ticks every 5 cycles, ch1 every 1000, ch2 periods of 8680/8681 with exactly 141 long periods per 256 ticks.
2. cfg_wen ch0 div=3 mid-period (cnt=2 of 5) -> current period completes at 5, pend_o[0]=1 until that tick, then period 3.
3. sync_i[1] at cnt=500 with div=1000 -> no tick at the old phase; next tick exactly 1000 cycles after sync; acc=0.
4. cfg_wen and sync_i same cycle on ch0, div=7 -> next tick 7 cycles later, pend_o[0] never visible high.
5. ch0 div=0 frac=0 -> tick_o[0]=1 every cycle; div=2 frac=128 -> periods alternate 2,3 (average 2.5).
6. en_i[2] dropped for 20 cycles with a pending write, then raised -> no ticks while low, pend cleared immediately, first tick `div` cycles after enable.

Source files
------------

// File: rtl/tick_gen_multi_pkg.sv
// ----------------------------------------------------------------------------
// tick_gen_multi_pkg
//   Shared constants and types for the multi-channel tick generator.
//   Holds the system frequencies, the divisors derived from them and the
//   per-channel reset configuration. Channel 0 is the peripheral enable,
//   channel 1 the RTC (CLINT mtime) enable and channel 2 the UART bit-rate
//   enable.
// ----------------------------------------------------------------------------
package tick_gen_multi_pkg;

   // System frequencies in Hz. The UART ratio cpu/baud = 8680.55 is not an
   // integer; the fractional divisor recovers the remainder.
   localparam int CPU_FREQ   = 868_055_000;
   localparam int PER_FREQ   = 173_611_000;
   localparam int RTC_FREQ   = 868_055;
   localparam int BAUDRATE   = 100_000;

   // Field widths of the default configuration table.
   localparam int CFG_DIV_W  = 16;
   localparam int CFG_FRAC_W = 8;

   // Derived integer divisors.
   localparam int PER_DIV    = CPU_FREQ / PER_FREQ;   // 5
   localparam int RTC_DIV    = CPU_FREQ / RTC_FREQ;   // 1000
   localparam int BAUD_DIV   = CPU_FREQ / BAUDRATE;   // 8680

   // Rounded fractional part of cpu/baud in units of 1/2^CFG_FRAC_W cycle.
   localparam int BAUD_FRAC  =
      ((CPU_FREQ % BAUDRATE) * (1 << CFG_FRAC_W) + BAUDRATE / 2) / BAUDRATE;  // 141

   // Channel roles.
   typedef enum int {
      CH_PER  = 0,
      CH_RTC  = 1,
      CH_BAUD = 2
   } tick_ch_e;

   // One channel configuration: integer divisor plus fractional divisor.
   typedef struct packed {
      logic [CFG_DIV_W-1:0]  div;
      logic [CFG_FRAC_W-1:0] frac;
   } tick_cfg_t;

   localparam int NUM_DEF = 3;

   localparam tick_cfg_t DEF_CFG [NUM_DEF] = '{
      '{div: CFG_DIV_W'(PER_DIV),  frac: '0},
      '{div: CFG_DIV_W'(RTC_DIV),  frac: '0},
      '{div: CFG_DIV_W'(BAUD_DIV), frac: CFG_FRAC_W'(BAUD_FRAC)}
   };

   // Reset divisor of a channel; channels without a table entry divide by 1.
   // The loop keeps every table access in range for any channel number.
   function automatic int def_div(int ch);
      int r = 1;
      for (int i = 0; i < NUM_DEF; i++)
         if (i == ch) r = int'(DEF_CFG[i].div);
      return r;
   endfunction

   // Reset fractional divisor of a channel; 0 for channels without an entry.
   function automatic int def_frac(int ch);
      int r = 0;
      for (int i = 0; i < NUM_DEF; i++)
         if (i == ch) r = int'(DEF_CFG[i].frac);
      return r;
   endfunction

endpackage

// File: rtl/tick_gen_multi_if.sv
// ----------------------------------------------------------------------------
// tick_gen_multi_if
//   Control/status bundle of the tick generator.
//   en_i     per-channel enable
//   sync_i   per-channel phase restart pulse
//   cfg_wen  config write strobe, cfg_ch selects the channel,
//   cfg_div  integer divisor, cfg_frac fractional divisor
//   tick_o   one-cycle tick per channel
//   pend_o   per-channel flag: shadow config not yet applied
//   master: the block driving enables/config; slave: the tick generator.
// ----------------------------------------------------------------------------
interface tick_gen_multi_if #(
   parameter int NCH    = 3,
   parameter int DIV_W  = 16,
   parameter int FRAC_W = 8
);
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]    en_i;
   logic [NCH-1:0]    sync_i;
   logic              cfg_wen;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [FRAC_W-1:0] cfg_frac;
   logic [NCH-1:0]    tick_o;
   logic [NCH-1:0]    pend_o;

   modport master (
      output en_i, sync_i, cfg_wen, cfg_ch, cfg_div, cfg_frac,
      input  tick_o, pend_o
   );

   modport slave (
      input  en_i, sync_i, cfg_wen, cfg_ch, cfg_div, cfg_frac,
      output tick_o, pend_o
   );

endinterface

// File: rtl/tick_gen_multi_chan.sv
// ----------------------------------------------------------------------------
// tick_chan
//   One tick channel: period counter, fractional phase accumulator and a
//   shadow/active configuration pair.
//   clock, reset   system clock, synchronous active-low reset
//   en_i           channel enable (low: counter/accumulator held at 0)
//   sync_i         phase restart pulse
//   wen_i          config write for this channel, data in div_i/frac_i
//   tick_o         registered one-cycle tick
//   pend_o         shadow config waiting to be applied
//
//   Period length is max(div,1) + carry, where carry is the overflow of the
//   fractional accumulator taken at the tick that opened the period, so the
//   average period is div + frac/2^FRAC_W cycles.
// ----------------------------------------------------------------------------
module tick_chan #(
   parameter int                DIV_W    = 16,
   parameter int                FRAC_W   = 8,
   parameter logic [DIV_W-1:0]  DEF_DIV  = DIV_W'(1),
   parameter logic [FRAC_W-1:0] DEF_FRAC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en_i,
   input  logic              sync_i,
   input  logic              wen_i,
   input  logic [DIV_W-1:0]  div_i,
   input  logic [FRAC_W-1:0] frac_i,
   output logic              tick_o,
   output logic              pend_o
);

   logic [DIV_W-1:0]  cnt;
   logic [FRAC_W-1:0] acc;
   logic              carry;
   logic              tick_q;
   logic              pend;
   logic [DIV_W-1:0]  act_div,  shd_div;
   logic [FRAC_W-1:0] act_frac, shd_frac;

   logic [DIV_W-1:0]  div_min;
   logic [DIV_W:0]    last;
   logic              restart;
   logic              tick_now;
   logic              apply;
   logic [FRAC_W-1:0] eff_frac;
   logic [FRAC_W:0]   acc_sum;

   always_comb begin
      restart  = ~en_i | sync_i;
      div_min  = (act_div == '0) ? DIV_W'(1) : act_div;
      // One extra bit: div = 2^DIV_W-1 plus a carry gives a full 2^DIV_W period.
      last     = {1'b0, div_min} - (DIV_W+1)'(1) + (DIV_W+1)'(carry);
      tick_now = ~restart & ({1'b0, cnt} == last);
      // A write landing on the tick cycle keeps the old config for this tick
      // and waits in the shadow for the next one (the newest write wins).
      apply    = pend & (restart | (tick_now & ~wen_i));
      // The carry for the next period is taken with the config that will be
      // active for that period.
      eff_frac = apply ? shd_frac : act_frac;
      acc_sum  = {1'b0, acc} + {1'b0, eff_frac};
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt      <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         tick_q   <= 1'b0;
         pend     <= 1'b0;
         act_div  <= DEF_DIV;
         act_frac <= DEF_FRAC;
         shd_div  <= DEF_DIV;
         shd_frac <= DEF_FRAC;
      end else begin
         tick_q <= tick_now;

         // Phase: restart clears everything, a tick closes the period.
         if (restart) begin
            cnt   <= '0;
            acc   <= '0;
            carry <= 1'b0;
         end else if (tick_now) begin
            cnt   <= '0;
            acc   <= acc_sum[FRAC_W-1:0];
            carry <= acc_sum[FRAC_W];
         end else begin
            cnt   <= cnt + DIV_W'(1);
         end

         // Config: active only changes at a period boundary, so no period is
         // ever cut short or stretched by a write.
         if (wen_i) begin
            shd_div  <= div_i;
            shd_frac <= frac_i;
         end
         if (wen_i && restart) begin
            act_div  <= div_i;
            act_frac <= frac_i;
            pend     <= 1'b0;
         end else if (wen_i) begin
            pend     <= 1'b1;
         end else if (apply) begin
            act_div  <= shd_div;
            act_frac <= shd_frac;
            pend     <= 1'b0;
         end
      end
   end

   assign tick_o = tick_q;
   assign pend_o = pend;

endmodule

// File: rtl/tick_gen_multi.sv
// ----------------------------------------------------------------------------
// tick_gen_multi
//   Multi-channel tick generator. Produces one-cycle clock-enable pulses for
//   the peripheral, RTC and UART bit-rate domains from the cpu clock, with
//   runtime-programmable integer + fractional divisors.
//   clock   system clock
//   reset   synchronous active-low reset
//   bus     tick_gen_multi_if.slave: en_i, sync_i, cfg_* in; tick_o, pend_o out
//   The top only decodes the config write to its channel; each channel is
//   an independent tick_chan.
// ----------------------------------------------------------------------------
module tick_gen_multi
   import tick_gen_multi_pkg::*;
#(
   parameter int NCH    = 3,
   parameter int DIV_W  = 16,
   parameter int FRAC_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   tick_gen_multi_if.slave   bus
);

   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0] wen_ch;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] pend;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign wen_ch[g] = bus.cfg_wen & (bus.cfg_ch == CH_W'(g));

      tick_chan #(
         .DIV_W    (DIV_W),
         .FRAC_W   (FRAC_W),
         .DEF_DIV  (DIV_W'(def_div(g))),
         .DEF_FRAC (FRAC_W'(def_frac(g)))
      ) u_chan (
         .clock  (clock),
         .reset  (reset),
         .en_i   (bus.en_i[g]),
         .sync_i (bus.sync_i[g]),
         .wen_i  (wen_ch[g]),
         .div_i  (bus.cfg_div),
         .frac_i (bus.cfg_frac),
         .tick_o (tick[g]),
         .pend_o (pend[g])
      );
   end

   assign bus.tick_o = tick;
   assign bus.pend_o = pend;

endmodule

// File: tb/tb_tick_gen_multi.sv
// ----------------------------------------------------------------------------
// tb_tick_gen_multi
//   Scoreboard bench. The stimulus process advances an event-scheduled model
//   (absolute tick times per channel, fractional phase kept as an integer
//   remainder) and pushes the expected tick/pend vectors for every clock
//   edge; a monitor pops one entry per cycle and compares.
// ----------------------------------------------------------------------------
module tb_tick_gen_multi;

   localparam int NCH    = 3;
   localparam int DIV_W  = 16;
   localparam int FRAC_W = 8;
   localparam int FSCALE = 1 << FRAC_W;

   typedef struct {
      logic [NCH-1:0] tick;
      logic [NCH-1:0] pend;
      longint         edge_n;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;

   tick_gen_multi_if #(.NCH(NCH), .DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

   tick_gen_multi #(.NCH(NCH), .DIV_W(DIV_W), .FRAC_W(FRAC_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Reference configuration after reset.
   int def_d [NCH] = '{5, 1000, 8680};
   int def_f [NCH] = '{0, 0, 141};

   // Model state.
   int     a_div [NCH], a_frac [NCH], s_div [NCH], s_frac [NCH], m_acc [NCH];
   bit     m_pend [NCH];
   longint nxt [NCH];
   longint e = 0;

   exp_t   sb_q [$];
   longint t2_q [$];
   bit     rec2 = 0, rec2_end = 0, chk2_done = 0;
   int     n_cmp = 0, n_bad = 0, nlong;
   exp_t   mx;

   function automatic int max1(int d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   // Predict the outputs after the coming clock edge, then take the edge.
   task automatic step();
      exp_t x;
      int   sum;
      bit   w;
      e++;
      x.edge_n = e;
      x.tick   = '0;
      x.pend   = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         w = bus.cfg_wen && (int'(bus.cfg_ch) == ch);
         if (!reset) begin
            a_div[ch] = def_d[ch]; a_frac[ch] = def_f[ch];
            s_div[ch] = def_d[ch]; s_frac[ch] = def_f[ch];
            m_pend[ch] = 0; m_acc[ch] = 0;
            nxt[ch] = e + max1(a_div[ch]);
         end else if (!bus.en_i[ch] || bus.sync_i[ch]) begin
            if (w) begin
               a_div[ch] = int'(bus.cfg_div); a_frac[ch] = int'(bus.cfg_frac);
               s_div[ch] = a_div[ch];         s_frac[ch] = a_frac[ch];
               m_pend[ch] = 0;
            end else if (m_pend[ch]) begin
               a_div[ch] = s_div[ch]; a_frac[ch] = s_frac[ch]; m_pend[ch] = 0;
            end
            m_acc[ch] = 0;
            nxt[ch] = e + max1(a_div[ch]);
         end else begin
            if (e == nxt[ch]) begin
               x.tick[ch] = 1'b1;
               if (!w && m_pend[ch]) begin
                  a_div[ch] = s_div[ch]; a_frac[ch] = s_frac[ch]; m_pend[ch] = 0;
               end
               sum = m_acc[ch] + a_frac[ch];
               nxt[ch] = e + max1(a_div[ch]) + sum / FSCALE;
               m_acc[ch] = sum % FSCALE;
            end
            if (w) begin
               s_div[ch] = int'(bus.cfg_div); s_frac[ch] = int'(bus.cfg_frac);
               m_pend[ch] = 1;
            end
         end
         x.pend[ch] = m_pend[ch];
      end
      sb_q.push_back(x);
      @(posedge clock);
      #1;
      if (n_bad >= 100) finish_run();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input int ch, input int dv, input int fr, input bit sy);
      bus.cfg_wen  = 1'b1;
      bus.cfg_ch   = 2'(ch);
      bus.cfg_div  = 16'(dv);
      bus.cfg_frac = 8'(fr);
      if (sy) bus.sync_i[ch] = 1'b1;
      step();
      bus.cfg_wen = 1'b0;
      bus.sync_i  = '0;
   endtask

   // Monitor: one scoreboard entry per clock edge.
   always @(negedge clock) begin
      if (sb_q.size() > 0) begin
         mx = sb_q.pop_front();
         n_cmp++;
         if (bus.tick_o !== mx.tick) begin
            n_bad++;
            $display("FAIL tick edge=%0d got=%b want=%b", mx.edge_n, bus.tick_o, mx.tick);
         end
         n_cmp++;
         if (bus.pend_o !== mx.pend) begin
            n_bad++;
            $display("FAIL pend edge=%0d got=%b want=%b", mx.edge_n, bus.pend_o, mx.pend);
         end
         if (rec2 && bus.tick_o[2] === 1'b1) t2_q.push_back(mx.edge_n);
      end
      // 256 periods after the first tick of a fresh phase must hold exactly
      // 141 long (3-cycle) periods for div=2 frac=141.
      if (rec2_end && !chk2_done) begin
         chk2_done = 1;
         nlong = 0;
         if (t2_q.size() >= 257)
            for (int i = 1; i <= 256; i++)
               if (t2_q[i] - t2_q[i-1] == 3) nlong++;
         n_cmp++;
         if (t2_q.size() < 257 || nlong != 141) begin
            n_bad++;
            $display("FAIL frac_long_periods ticks=%0d long=%0d want ticks>=257 long=141",
                     t2_q.size(), nlong);
         end
      end
   end

   initial begin
      bus.en_i = '0; bus.sync_i = '0; bus.cfg_wen = 1'b0;
      bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_frac = '0;

      // Reset, then all channels on with defaults (ch2: three 8680/8681 periods).
      run(3);
      bus.en_i = 3'b111;
      reset = 1'b1;
      run(26100);

      // ch0 div=3 written at cnt=2 of 5: current period completes first.
      for (int i = 0; i < 50 && nxt[0] != e + 3; i++) step();
      wr(0, 3, 0, 0);
      run(20);

      // ch1 sync at cnt=500: next tick 1000 cycles after the sync.
      for (int i = 0; i < 2000 && nxt[1] != e + 500; i++) step();
      bus.sync_i[1] = 1'b1;
      step();
      bus.sync_i = '0;
      run(1010);

      // Write + sync together on ch0: div=7 applies at once.
      wr(0, 7, 0, 1);
      run(20);

      // div=0 ticks every cycle; div=2 frac=128 alternates 2/3.
      wr(0, 0, 0, 0);
      run(20);
      wr(0, 2, 128, 0);
      run(30);

      // ch2 pending write, then disabled for 20 cycles, then re-enabled.
      wr(2, 6, 0, 0);
      run(3);
      bus.en_i[2] = 1'b0;
      run(20);
      bus.en_i[2] = 1'b1;
      run(30);

      // Random traffic on all channels.
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 199) == 0) bus.en_i[c] = ~bus.en_i[c];
            if ($urandom_range(0, 99) == 0)  bus.sync_i[c] = 1'b1;
         end
         if ($urandom_range(0, 14) == 0) begin
            bus.cfg_wen  = 1'b1;
            bus.cfg_ch   = 2'($urandom_range(0, NCH-1));
            bus.cfg_div  = 16'($urandom_range(0, 9));
            bus.cfg_frac = 8'($urandom_range(0, 255));
         end
         step();
         bus.cfg_wen = 1'b0;
         bus.sync_i  = '0;
      end

      // Reset in the middle of running periods.
      bus.en_i = 3'b111;
      run(7);
      reset = 1'b0;
      run(2);
      reset = 1'b1;
      run(30);

      // ch2 fractional long-period count.
      rec2 = 1;
      wr(2, 2, 141, 1);
      run(700);
      rec2_end = 1;
      run(3);

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clock);
      finish_run();
   end

endmodule
